// File: rtl/flash_boot_seq.sv
// Boot loader: issues one SPI READ (0x03) command to a serial flash, streams
// NUM_WORDS 32-bit words back and writes each one to consecutive Wishbone addresses.
module flash_boot_seq #(
    parameter int          NUM_WORDS  = 90,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter logic [31:0] WB_BASE    = 32'h0000_0000,
    parameter int          CLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bypass_en,
    input  logic        host_mosi,
    input  logic        flash_miso,
    output logic        flash_clk,
    output logic        flash_mosi,
    output logic        flash_csb,
    output logic [31:0] wbs_adr,
    output logic [31:0] wbs_dat,
    output logic        wbs_cyc,
    output logic        wbs_stb,
    output logic        wbs_we,
    input  logic        wbs_ack,
    output logic [2:0]  state,
    output logic        done_loading
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_WORDS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]      CMD_WORD = {8'h03, FLASH_ADDR};

    state_t             state_q,    state_d;
    logic [DIV_W-1:0]   div_q,      div_d;
    logic               fclk_q,     fclk_d;
    logic               csb_q,      csb_d;
    logic [31:0]        cmd_q,      cmd_d;
    logic [31:0]        shin_q,     shin_d;
    logic [5:0]         bitcnt_q,   bitcnt_d;
    logic               frame_q,    frame_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               wb_q,       wb_d;
    logic [31:0]        adr_q,      adr_d;
    logic [31:0]        dat_q,      dat_d;
    logic               done_q,     done_d;
    logic               tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            fclk_q     <= 1'b0;
            csb_q      <= 1'b1;
            cmd_q      <= '0;
            shin_q     <= '0;
            bitcnt_q   <= '0;
            frame_q    <= 1'b0;
            word_idx_q <= '0;
            wb_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            fclk_q     <= fclk_d;
            csb_q      <= csb_d;
            cmd_q      <= cmd_d;
            shin_q     <= shin_d;
            bitcnt_q   <= bitcnt_d;
            frame_q    <= frame_d;
            word_idx_q <= word_idx_d;
            wb_q       <= wb_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        fclk_d     = fclk_q;
        csb_d      = csb_q;
        cmd_d      = cmd_q;
        shin_d     = shin_q;
        bitcnt_d   = bitcnt_q;
        frame_d    = frame_q;
        word_idx_d = word_idx_q;
        wb_d       = wb_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = done_q;

        case (state_q)
            S_IDLE: begin
                if (!bypass_en) begin
                    state_d  = S_CMD;
                    csb_d    = 1'b0;
                    fclk_d   = 1'b0;
                    div_d    = '0;
                    bitcnt_d = '0;
                    frame_d  = 1'b0;
                    cmd_d    = CMD_WORD;
                end
            end
            S_CMD, S_READ: begin
                if (tick) begin
                    div_d  = '0;
                    fclk_d = ~fclk_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                // Rising flash_clk: sample MISO and count the bit
                if (tick && !fclk_q) begin
                    shin_d = {shin_q[30:0], flash_miso};
                    if (bitcnt_q == 6'd31) begin
                        bitcnt_d = '0;
                        if (state_q == S_CMD) state_d = S_READ;
                        else                  frame_d = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 6'd1;
                    end
                end
                // Falling flash_clk: next MOSI bit; a finished word leaves on this
                // edge so the flash sees its last full clock before the pause.
                if (tick && fclk_q) begin
                    cmd_d = {cmd_q[30:0], 1'b0};
                    if (frame_q) begin
                        frame_d = 1'b0;
                        state_d = S_WRITE;
                        wb_d    = 1'b1;
                        adr_d   = WB_BASE + (32'(word_idx_q) << 2);
                        dat_d   = shin_q;
                    end
                end
            end
            S_WRITE: begin
                if (wbs_ack) begin
                    wb_d       = 1'b0;
                    word_idx_d = word_idx_q + IDX_W'(1);
                    div_d      = '0;
                    if (word_idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        csb_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign flash_clk    = fclk_q;
    assign flash_csb    = csb_q;
    assign flash_mosi   = reset ? 1'b0 :
                          (bypass_en && (state_q == S_IDLE || state_q == S_DONE)) ? host_mosi :
                          cmd_q[31];
    assign wbs_adr      = adr_q;
    assign wbs_dat      = dat_q;
    assign wbs_cyc      = wb_q;
    assign wbs_stb      = wb_q;
    assign wbs_we       = wb_q;
    assign state        = state_q;
    assign done_loading = done_q;

endmodule

// File: tb/tb_flash_boot_seq.sv
// Directed bench for flash_boot_seq: flash stream model, Wishbone slave with
// programmable ack delay, and hand-computed expectations.
module tb_flash_boot_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        bypass_en;
    logic        host_mosi;
    logic        flash_miso;
    logic        flash_clk, flash_mosi, flash_csb;
    logic [31:0] wbs_adr, wbs_dat;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic        ack, stray_ack;
    logic [2:0]  state;
    logic        done_loading;

    int checks = 0;
    int failures = 0;

    logic [31:0] words [0:89];
    int          rise_cnt;
    int          wr_rises = 0;
    logic [31:0] cmd_cap;

    int          ack_delay;
    bit          stall_en;
    bit          in_wait;
    int          wait_cnt;
    logic [31:0] cap_adr, cap_dat;
    logic [31:0] log_adr [0:127];
    logic [31:0] log_dat [0:127];
    int          nwr;

    always #5 clk = ~clk;

    flash_boot_seq dut (
        .clk          (clk),
        .reset        (reset),
        .bypass_en    (bypass_en),
        .host_mosi    (host_mosi),
        .flash_miso   (flash_miso),
        .flash_clk    (flash_clk),
        .flash_mosi   (flash_mosi),
        .flash_csb    (flash_csb),
        .wbs_adr      (wbs_adr),
        .wbs_dat      (wbs_dat),
        .wbs_cyc      (wbs_cyc),
        .wbs_stb      (wbs_stb),
        .wbs_we       (wbs_we),
        .wbs_ack      (ack | stray_ack),
        .state        (state),
        .done_loading (done_loading)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash model: the first 32 rising edges carry the command; afterwards each
    // rising edge consumes one data bit and the next one is presented.
    always @(posedge flash_clk or posedge reset) begin
        if (reset) begin
            rise_cnt   = 0;
            cmd_cap    = '0;
            flash_miso = 1'b0;
        end else begin
            if (state == 3'd3) wr_rises++;
            if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], flash_mosi};
            rise_cnt++;
            if (rise_cnt >= 32) begin
                int idx, w, b;
                logic [31:0] cur;
                idx = rise_cnt - 32;
                w   = idx / 32;
                b   = 31 - (idx % 32);
                if (w < 90) begin
                    cur        = words[w];
                    flash_miso = cur[b];
                end else begin
                    flash_miso = 1'b0;
                end
            end
        end
    end

    // Wishbone slave: acks ack_delay clocks after the strobe first appears.
    always @(negedge clk) begin
        if (reset) begin
            ack      = 1'b0;
            in_wait  = 1'b0;
            wait_cnt = 0;
            nwr      = 0;
        end else if (ack) begin
            ack = 1'b0;
        end else begin
            if (!in_wait && wbs_stb) begin
                in_wait  = 1'b1;
                wait_cnt = 0;
                cap_adr  = wbs_adr;
                cap_dat  = wbs_dat;
            end else if (in_wait && stall_en) begin
                check_eq("stall_stb",  {31'd0, wbs_stb},   32'd1);
                check_eq("stall_adr",  wbs_adr,            cap_adr);
                check_eq("stall_dat",  wbs_dat,            cap_dat);
                check_eq("stall_fclk", {31'd0, flash_clk}, 32'd0);
            end
            if (in_wait) begin
                if (wait_cnt >= ack_delay) begin
                    ack     = 1'b1;
                    in_wait = 1'b0;
                    if (nwr < 128) begin
                        log_adr[nwr] = wbs_adr;
                        log_dat[nwr] = wbs_dat;
                    end
                    nwr++;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        int  bad;
        bit  hit;
        logic [31:0] last_word;
        logic hv [0:2];

        reset     = 1'b1;
        bypass_en = 1'b0;
        host_mosi = 1'b0;
        stray_ack = 1'b0;
        ack_delay = 0;
        stall_en  = 1'b0;
        words[0]  = 32'hDEADBEEF;
        words[1]  = 32'h12345678;
        for (int i = 2; i < 90; i++) words[i] = $urandom;

        repeat (3) @(negedge clk);
        check_eq("rst_state", {29'd0, state},         32'd0);
        check_eq("rst_csb",   {31'd0, flash_csb},     32'd1);
        check_eq("rst_fclk",  {31'd0, flash_clk},     32'd0);
        check_eq("rst_mosi",  {31'd0, flash_mosi},    32'd0);
        check_eq("rst_cyc",   {31'd0, wbs_cyc},       32'd0);
        check_eq("rst_stb",   {31'd0, wbs_stb},       32'd0);
        check_eq("rst_we",    {31'd0, wbs_we},        32'd0);
        check_eq("rst_adr",   wbs_adr,                32'd0);
        check_eq("rst_dat",   wbs_dat,                32'd0);
        check_eq("rst_done",  {31'd0, done_loading},  32'd0);

        // Full load with immediate ack
        reset = 1'b0;
        @(negedge clk);
        check_eq("csb_fall", {31'd0, flash_csb}, 32'd0);
        check_eq("cmd_state", {29'd0, state}, 32'd1);
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            if (state == 3'd4) hit = 1'b1;
        end
        check_eq("done_reached", {31'd0, hit}, 32'd1);
        check_eq("done_state", {29'd0, state},        32'd4);
        check_eq("done_flag",  {31'd0, done_loading}, 32'd1);
        check_eq("done_csb",   {31'd0, flash_csb},    32'd1);
        check_eq("done_fclk",  {31'd0, flash_clk},    32'd0);
        check_eq("done_cyc",   {31'd0, wbs_cyc},      32'd0);
        check_eq("cmd_word",   cmd_cap,               32'h03000000);
        check_eq("wr_count",   nwr,                   32'd90);
        check_eq("wr0_adr",    log_adr[0],            32'h0);
        check_eq("wr0_dat",    log_dat[0],            32'hDEADBEEF);
        check_eq("wr1_adr",    log_adr[1],            32'h4);
        check_eq("wr1_dat",    log_dat[1],            32'h12345678);
        last_word = words[89];
        check_eq("wr89_adr",   log_adr[89],           32'h164);
        check_eq("wr89_dat",   log_dat[89],           last_word);
        bad = 0;
        for (int i = 0; i < 90; i++)
            if (log_dat[i] !== words[i] || log_adr[i] !== 32'(i * 4)) bad++;
        check_eq("all_words", bad, 32'd0);
        repeat (20) @(negedge clk);
        check_eq("no_extra_wr", nwr, 32'd90);
        check_eq("done_sticky", {29'd0, state}, 32'd4);

        // Bypass in DONE
        bypass_en = 1'b1;
        host_mosi = 1'b1;
        #1 check_eq("done_byp_1", {31'd0, flash_mosi}, 32'd1);
        host_mosi = 1'b0;
        #1 check_eq("done_byp_0", {31'd0, flash_mosi}, 32'd0);

        // Bypass held from reset
        @(negedge clk);
        reset     = 1'b1;
        host_mosi = 1'b1;
        #1 check_eq("rst_byp_mosi", {31'd0, flash_mosi}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hv[0] = 1'b0; hv[1] = 1'b1; hv[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            host_mosi = hv[k];
            @(negedge clk);
            check_eq("byp_mosi",  {31'd0, flash_mosi}, {31'd0, hv[k]});
            check_eq("byp_state", {29'd0, state},      32'd0);
        end

        // Release bypass into a stalled-ack load
        ack_delay = 10;
        stall_en  = 1'b1;
        bypass_en = 1'b0;
        @(negedge clk);
        check_eq("byp_rel_state", {29'd0, state},     32'd1);
        check_eq("byp_rel_csb",   {31'd0, flash_csb}, 32'd0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_ack", {29'd0, state}, 32'd1);

        hit = 1'b0;
        for (int c = 0; c < 5000 && !hit; c++) begin
            @(negedge clk);
            if (nwr == 5 && wbs_stb) hit = 1'b1;
        end
        check_eq("word5_write", {31'd0, hit}, 32'd1);
        check_eq("stall_wr0_adr", log_adr[0], 32'h0);
        check_eq("stall_wr4_adr", log_adr[4], 32'h10);

        // Asynchronous reset in the middle of the word-5 write
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_state", {29'd0, state},        32'd0);
        check_eq("mid_csb",   {31'd0, flash_csb},    32'd1);
        check_eq("mid_fclk",  {31'd0, flash_clk},    32'd0);
        check_eq("mid_cyc",   {31'd0, wbs_cyc},      32'd0);
        check_eq("mid_stb",   {31'd0, wbs_stb},      32'd0);
        check_eq("mid_we",    {31'd0, wbs_we},       32'd0);
        check_eq("mid_adr",   wbs_adr,               32'd0);
        check_eq("mid_dat",   wbs_dat,               32'd0);
        check_eq("mid_mosi",  {31'd0, flash_mosi},   32'd0);
        check_eq("mid_done",  {31'd0, done_loading}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (nwr >= 1) hit = 1'b1;
        end
        check_eq("restart_wr",     {31'd0, hit}, 32'd1);
        check_eq("restart_adr",    log_adr[0],   32'h0);
        check_eq("restart_dat",    log_dat[0],   32'hDEADBEEF);
        check_eq("restart_cmd",    cmd_cap,      32'h03000000);
        check_eq("no_write_rises", wr_rises,     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
